// File: rtl/bomberman_pkg.sv
`timescale 1ns/1ps
// bomberman_pkg: arena geometry and bomb FSM encoding shared by the
// bomb controller, the bomberman sprite logic and the blocked-tile compare.
package bomberman_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    EXPLODE = 2'd2
  } bomb_state_t;

  localparam int TILE  = 16;  // tile edge in pixels, power of 2
  localparam int X_OFS = 48;  // arena left edge in pixels
  localparam int Y_OFS = 32;  // arena top edge in pixels

endpackage

// File: rtl/tile_snap.sv
`timescale 1ns/1ps
// tile_snap: maps a 10-bit pixel coordinate onto an arena tile index.
//   ROUND = 1 adds half a tile first, so a sprite top-left snaps to the tile
//   under its centre. Coordinates before the arena origin clamp to tile 0.
// Ports:
//   pix  in  10  pixel coordinate (x or y)
//   tile out  6  tile index relative to the arena origin OFS
module tile_snap #(
  parameter int TILE  = 16,
  parameter int OFS   = 0,
  parameter bit ROUND = 1'b0
) (
  input  logic [9:0] pix,
  output logic [5:0] tile
);

  localparam int SH = $clog2(TILE);
  localparam logic signed [11:0] HALF  = 12'(ROUND ? (TILE / 2) : 0);
  localparam logic signed [11:0] OFS_S = 12'(OFS);

  logic signed [11:0] rel;

  // Negative offsets clamp to 0; indices beyond 6 bits saturate at 63.
  function automatic logic [5:0] clamp_tile(input logic signed [11:0] r);
    logic signed [11:0] idx;
    idx = r >>> SH;
    if (r < 12'sd0)        return 6'd0;
    else if (idx > 12'sd63) return 6'd63;
    else                   return idx[5:0];
  endfunction

  assign rel  = signed'({2'b00, pix}) + HALF - OFS_S;
  assign tile = clamp_tile(rel);

endmodule

// File: rtl/bomb_controller.sv
`timescale 1ns/1ps
// bomb_controller: sequences the player's single bomb (place, fuse, explode,
// rearm), snaps it to the tile grid and produces per-pixel bomb/blast flags
// plus a one-shot player-hit pulse.
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   C                place-bomb button (debounced level)
//   game_over        freezes timers and blocks placement
//   b_x, b_y         bomberman sprite top-left
//   v_x, v_y         current VGA pixel
//   bomb_active      bomb armed on the map
//   exp_active       explosion in progress
//   bomb_tx, bomb_ty bomb tile column/row (held after the bomb is gone)
//   bomb_on          pixel inside the bomb tile while armed
//   exp_on           pixel inside the blast cross while exploding
//   player_hit       single pulse per explosion when the player is caught
module bomb_controller
  import bomberman_pkg::*;
#(
  parameter int TICK_DIV   = 1666667,
  parameter int FUSE_TICKS = 180,
  parameter int EXP_TICKS  = 30,
  parameter int RANGE      = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       C,
  input  logic       game_over,
  input  logic [9:0] b_x,
  input  logic [9:0] b_y,
  input  logic [9:0] v_x,
  input  logic [9:0] v_y,
  output logic       bomb_active,
  output logic       exp_active,
  output logic [5:0] bomb_tx,
  output logic [5:0] bomb_ty,
  output logic       bomb_on,
  output logic       exp_on,
  output logic       player_hit
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX = (FUSE_TICKS > EXP_TICKS) ? FUSE_TICKS : EXP_TICKS;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [PW-1:0]      PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [TW-1:0]      FUSE_INIT  = TW'(FUSE_TICKS - 1);
  localparam logic [TW-1:0]      EXP_INIT   = TW'(EXP_TICKS - 1);
  localparam logic signed [6:0]  RNG        = 7'(RANGE);

  bomb_state_t   state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          c_q;
  logic          hit_latch, hit_nxt;
  logic          tile_ld;
  logic          tick;
  logic          place_req;
  logic          pix_in_arena;
  logic          ply_in_blast;
  logic [5:0]    snap_tx, snap_ty;
  logic [5:0]    pix_tx, pix_ty;
  logic [5:0]    ply_tx, ply_ty;

  // Cross-shaped blast test: same row or column, at most RANGE tiles away.
  function automatic logic in_cross(input logic [5:0] tx, input logic [5:0] ty,
                                    input logic [5:0] cx, input logic [5:0] cy);
    logic signed [6:0] dx;
    logic signed [6:0] dy;
    dx = signed'({1'b0, tx}) - signed'({1'b0, cx});
    dy = signed'({1'b0, ty}) - signed'({1'b0, cy});
    return ((dy == 7'sd0) && (dx <= RNG) && (dx >= -RNG)) ||
           ((dx == 7'sd0) && (dy <= RNG) && (dy >= -RNG));
  endfunction

  // Bomb placement tile (rounded to the sprite centre).
  tile_snap #(.TILE(TILE), .OFS(X_OFS), .ROUND(1'b1)) u_snap_bx (.pix(b_x), .tile(snap_tx));
  tile_snap #(.TILE(TILE), .OFS(Y_OFS), .ROUND(1'b1)) u_snap_by (.pix(b_y), .tile(snap_ty));
  // Tile under the current VGA pixel.
  tile_snap #(.TILE(TILE), .OFS(X_OFS), .ROUND(1'b0)) u_pix_x   (.pix(v_x), .tile(pix_tx));
  tile_snap #(.TILE(TILE), .OFS(Y_OFS), .ROUND(1'b0)) u_pix_y   (.pix(v_y), .tile(pix_ty));
  // Tile under the player's centre.
  tile_snap #(.TILE(TILE), .OFS(X_OFS), .ROUND(1'b1)) u_ply_x   (.pix(b_x), .tile(ply_tx));
  tile_snap #(.TILE(TILE), .OFS(Y_OFS), .ROUND(1'b1)) u_ply_y   (.pix(b_y), .tile(ply_ty));

  assign tick      = (presc == PRESC_LAST) && !game_over;
  assign place_req = C && !c_q;

  // Clamped pixel tiles would alias tile 0, so the margin is masked here.
  assign pix_in_arena = (v_x >= 10'(X_OFS)) && (v_y >= 10'(Y_OFS));
  assign ply_in_blast = in_cross(ply_tx, ply_ty, bomb_tx, bomb_ty);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      presc     <= '0;
      timer     <= '0;
      bomb_tx   <= '0;
      bomb_ty   <= '0;
      c_q       <= 1'b0;
      hit_latch <= 1'b0;
    end else begin
      state     <= state_nxt;
      presc     <= presc_nxt;
      timer     <= timer_nxt;
      c_q       <= C;
      hit_latch <= hit_nxt;
      if (tile_ld) begin
        bomb_tx <= snap_tx;
        bomb_ty <= snap_ty;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    hit_nxt   = hit_latch;
    tile_ld   = 1'b0;
    if (game_over)               presc_nxt = presc;
    else if (presc == PRESC_LAST) presc_nxt = '0;
    else                         presc_nxt = presc + 1'b1;

    case (state)
      IDLE: begin
        // Requests while a bomb is out are dropped, so only IDLE looks at C.
        if (place_req && !game_over) begin
          state_nxt = ARMED;
          timer_nxt = FUSE_INIT;
          tile_ld   = 1'b1;
        end
      end
      ARMED: begin
        if (tick) begin
          if (timer == '0) begin
            state_nxt = EXPLODE;
            timer_nxt = EXP_INIT;
            hit_nxt   = 1'b0;
          end else begin
            timer_nxt = timer - 1'b1;
          end
        end
      end
      EXPLODE: begin
        if (player_hit) hit_nxt = 1'b1;
        if (tick) begin
          if (timer == '0) state_nxt = IDLE;
          else             timer_nxt = timer - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bomb_active = (state == ARMED);
  assign exp_active  = (state == EXPLODE);
  assign bomb_on     = bomb_active && pix_in_arena && (pix_tx == bomb_tx) && (pix_ty == bomb_ty);
  assign exp_on      = exp_active && pix_in_arena && in_cross(pix_tx, pix_ty, bomb_tx, bomb_ty);
  assign player_hit  = exp_active && ply_in_blast && !hit_latch;

endmodule

// File: tb/tb_bomb_controller.sv
`timescale 1ns/1ps
module tb_bomb_controller;

  localparam int TICK_DIV   = 4;
  localparam int FUSE_TICKS = 3;
  localparam int EXP_TICKS  = 2;
  localparam int RANGE      = 2;
  localparam int TPX        = 16;
  localparam int XO         = 48;
  localparam int YO         = 32;

  logic       clk = 1'b0;
  logic       reset, C, game_over;
  logic [9:0] b_x, b_y, v_x, v_y;
  logic       bomb_active, exp_active, bomb_on, exp_on, player_hit;
  logic [5:0] bomb_tx, bomb_ty;

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;

  always #5 clk = ~clk;

  bomb_controller #(
    .TICK_DIV(TICK_DIV), .FUSE_TICKS(FUSE_TICKS), .EXP_TICKS(EXP_TICKS), .RANGE(RANGE)
  ) dut (
    .clk(clk), .reset(reset), .C(C), .game_over(game_over),
    .b_x(b_x), .b_y(b_y), .v_x(v_x), .v_y(v_y),
    .bomb_active(bomb_active), .exp_active(exp_active),
    .bomb_tx(bomb_tx), .bomb_ty(bomb_ty),
    .bomb_on(bomb_on), .exp_on(exp_on), .player_hit(player_hit)
  );

  always @(negedge clk) if (player_hit === 1'b1) hit_cnt++;

  // ---------------- reference model ----------------
  function automatic int snap_c(input int p, input int ofs);
    if (p + TPX / 2 < ofs) return 0;
    return (p + TPX / 2 - ofs) / TPX;
  endfunction

  function automatic bit in_blast(input int tx, input int ty, input int cx, input int cy);
    int ax, ay;
    ax = (tx > cx) ? tx - cx : cx - tx;
    ay = (ty > cy) ? ty - cy : cy - ty;
    return (ty == cy && ax <= RANGE) || (tx == cx && ay <= RANGE);
  endfunction

  int m_phase;   // 0 idle, 1 bomb on map, 2 exploding
  int m_left;    // ticks still to elapse in this phase
  int m_live;    // unfrozen cycles since reset
  int m_tx, m_ty;
  bit m_cprev, m_hit_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_phase = 0; m_left = 0; m_live = 0; m_tx = 0; m_ty = 0;
      m_cprev = 0; m_hit_done = 0;
    end else begin
      bit tk, hit_now;
      tk = !game_over && ((m_live % TICK_DIV) == TICK_DIV - 1);
      hit_now = (m_phase == 2) && !m_hit_done &&
                in_blast(snap_c(int'(b_x), XO), snap_c(int'(b_y), YO), m_tx, m_ty);
      if (!game_over) m_live++;
      case (m_phase)
        0: if (C && !m_cprev && !game_over) begin
             m_phase = 1; m_left = FUSE_TICKS;
             m_tx = snap_c(int'(b_x), XO); m_ty = snap_c(int'(b_y), YO);
           end
        1: if (tk) begin
             m_left--;
             if (m_left == 0) begin m_phase = 2; m_left = EXP_TICKS; m_hit_done = 0; end
           end
        default: begin
          if (hit_now) m_hit_done = 1;
          if (tk) begin
            m_left--;
            if (m_left == 0) m_phase = 0;
          end
        end
      endcase
      m_cprev = C;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic place_bomb();
    C = 1'b1;
    @(negedge clk);
    C = 1'b0;
  endtask

  task automatic run_length(input bit use_exp, output int n);
    n = 0;
    while (((use_exp ? exp_active : bomb_active) === 1'b1) && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(output bit ok);
    int k = 0;
    while ((bomb_active === 1'b1 || exp_active === 1'b1) && k < 100) begin
      k++;
      @(negedge clk);
    end
    ok = (bomb_active === 1'b0) && (exp_active === 1'b0);
  endtask

  task automatic wait_exp(output bit ok);
    int k = 0;
    while (exp_active !== 1'b1 && k < 100) begin
      k++;
      @(negedge clk);
    end
    ok = (exp_active === 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; C = 1'b0; game_over = 1'b0;
    b_x = 10'd48; b_y = 10'd32; v_x = 10'd50; v_y = 10'd40;
    repeat (3) @(negedge clk);
    checks++; if (bomb_active !== 1'b0) begin errors++; $display("FAIL reset_bomb_active got %b want 0", bomb_active); end
    checks++; if (exp_active !== 1'b0) begin errors++; $display("FAIL reset_exp_active got %b want 0", exp_active); end
    checks++; if (bomb_tx !== 6'd0) begin errors++; $display("FAIL reset_bomb_tx got %0d want 0", bomb_tx); end
    checks++; if (bomb_ty !== 6'd0) begin errors++; $display("FAIL reset_bomb_ty got %0d want 0", bomb_ty); end
    checks++; if (bomb_on !== 1'b0) begin errors++; $display("FAIL reset_bomb_on got %b want 0", bomb_on); end
    checks++; if (exp_on !== 1'b0) begin errors++; $display("FAIL reset_exp_on got %b want 0", exp_on); end
    checks++; if (player_hit !== 1'b0) begin errors++; $display("FAIL reset_player_hit got %b want 0", player_hit); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bomb_active !== 1'b0) begin errors++; $display("FAIL reset_release_idle got %b want 0", bomb_active); end
  endtask

  task automatic test_placement();
    int n_arm, n_exp;
    b_x = 10'd48; b_y = 10'd32;
    place_bomb();
    checks++; if (bomb_active !== 1'b1) begin errors++; $display("FAIL place_rise got %b want 1", bomb_active); end
    checks++; if (bomb_tx !== 6'd0 || bomb_ty !== 6'd0) begin errors++; $display("FAIL place_tile got %0d,%0d want 0,0", bomb_tx, bomb_ty); end
    run_length(1'b0, n_arm);
    checks++; if (n_arm < 9 || n_arm > 12) begin errors++; $display("FAIL armed_len got %0d want 9..12", n_arm); end
    checks++; if (exp_active !== 1'b1) begin errors++; $display("FAIL exp_follows got %b want 1", exp_active); end
    run_length(1'b1, n_exp);
    checks++; if (n_exp < 5 || n_exp > 8) begin errors++; $display("FAIL exp_len got %0d want 5..8", n_exp); end
    checks++; if (bomb_active !== 1'b0 || exp_active !== 1'b0) begin errors++; $display("FAIL back_idle got %b%b want 00", bomb_active, exp_active); end
  endtask

  task automatic test_snap();
    bit ok;
    b_x = 10'd71; b_y = 10'd40;
    place_bomb();
    checks++; if (bomb_tx !== 6'd1 || bomb_ty !== 6'd1) begin errors++; $display("FAIL snap_round got %0d,%0d want 1,1", bomb_tx, bomb_ty); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL snap_idle1 got busy want idle"); end
    b_x = 10'd40; b_y = 10'd5;
    place_bomb();
    checks++; if (bomb_tx !== 6'd0 || bomb_ty !== 6'd0) begin errors++; $display("FAIL snap_clamp got %0d,%0d want 0,0", bomb_tx, bomb_ty); end
    wait_idle(ok);
    b_x = 10'd199; b_y = 10'd88;
    place_bomb();
    checks++; if (bomb_tx !== 6'd9 || bomb_ty !== 6'd4) begin errors++; $display("FAIL snap_half got %0d,%0d want 9,4", bomb_tx, bomb_ty); end
    checks++; if (bomb_tx !== 6'(m_tx) || bomb_ty !== 6'(m_ty)) begin errors++; $display("FAIL snap_model got %0d,%0d want %0d,%0d", bomb_tx, bomb_ty, m_tx, m_ty); end
    wait_idle(ok);
    checks++; if (bomb_tx !== 6'd9 || bomb_ty !== 6'd4) begin errors++; $display("FAIL tile_hold got %0d,%0d want 9,4", bomb_tx, bomb_ty); end
  endtask

  task automatic test_hold();
    int rises, n;
    bit prev, ok;
    b_x = 10'd100; b_y = 10'd100;
    C = 1'b1;
    @(negedge clk);
    checks++; if (bomb_active !== 1'b1) begin errors++; $display("FAIL hold_first got %b want 1", bomb_active); end
    rises = 0; prev = bomb_active;
    repeat (60) begin
      @(negedge clk);
      if (bomb_active === 1'b1 && !prev) rises++;
      prev = bomb_active;
    end
    checks++; if (rises != 0 || bomb_active !== 1'b0) begin errors++; $display("FAIL hold_replace got rises=%0d active=%b want 0,0", rises, bomb_active); end
    C = 1'b0;
    @(negedge clk);
    place_bomb();
    C = 1'b1;
    @(negedge clk);
    C = 1'b0;
    checks++; if (bomb_active !== 1'b1) begin errors++; $display("FAIL armed_edge_kept got %b want 1", bomb_active); end
    run_length(1'b0, n);
    n = n + 1;
    checks++; if (n < 9 || n > 12) begin errors++; $display("FAIL armed_edge_len got %0d want 9..12", n); end
    run_length(1'b1, n);
    repeat (4) @(negedge clk);
    checks++; if (bomb_active !== 1'b0) begin errors++; $display("FAIL no_queue got %b want 0", bomb_active); end
    place_bomb();
    checks++; if (bomb_active !== 1'b1) begin errors++; $display("FAIL rearm got %b want 1", bomb_active); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hold_idle got busy want idle"); end
  endtask

  typedef struct { int tx; int ty; bit on; } pix_case_t;

  task automatic test_cross();
    pix_case_t tbl[6];
    int h0;
    bit ok;
    tbl[0] = '{3, 5, 1'b1}; tbl[1] = '{7, 5, 1'b1}; tbl[2] = '{5, 3, 1'b1};
    tbl[3] = '{5, 7, 1'b1}; tbl[4] = '{8, 5, 1'b0}; tbl[5] = '{6, 6, 1'b0};
    b_x = 10'd128; b_y = 10'd112;
    place_bomb();
    checks++; if (bomb_tx !== 6'd5 || bomb_ty !== 6'd5) begin errors++; $display("FAIL cross_tile got %0d,%0d want 5,5", bomb_tx, bomb_ty); end
    v_x = 10'(XO + 5 * TPX + 4); v_y = 10'(YO + 5 * TPX + 9);
    #0.5;
    checks++; if (bomb_on !== 1'b1) begin errors++; $display("FAIL bomb_on_in got %b want 1", bomb_on); end
    v_x = 10'(XO + 6 * TPX);
    #0.5;
    checks++; if (bomb_on !== 1'b0) begin errors++; $display("FAIL bomb_on_out got %b want 0", bomb_on); end
    b_y = 10'd128;
    h0 = hit_cnt;
    wait_exp(ok);
    checks++; if (!ok) begin errors++; $display("FAIL cross_exp_wait got timeout want explode"); end
    for (int i = 0; i < 6; i++) begin
      v_x = 10'(XO + tbl[i].tx * TPX + 15);
      v_y = 10'(YO + tbl[i].ty * TPX + 1);
      #0.5;
      checks++;
      if (exp_on !== tbl[i].on) begin
        errors++;
        $display("FAIL exp_on_%0d_%0d got %b want %b", tbl[i].tx, tbl[i].ty, exp_on, tbl[i].on);
      end
    end
    wait_idle(ok);
    repeat (3) @(negedge clk);
    checks++; if (hit_cnt - h0 != 1) begin errors++; $display("FAIL player_hit_count got %0d want 1", hit_cnt - h0); end
  endtask

  task automatic test_freeze();
    int n, r, bad;
    b_x = 10'd48; b_y = 10'd32;
    place_bomb();
    n = 1;
    repeat (2) begin
      @(negedge clk);
      if (bomb_active === 1'b1) n++;
    end
    game_over = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bomb_active !== 1'b1 || exp_active !== 1'b0) bad++;
    end
    game_over = 1'b0;
    checks++; if (bad != 0) begin errors++; $display("FAIL freeze_state got %0d bad cycles want 0", bad); end
    @(negedge clk);
    run_length(1'b0, r);
    checks++; if (n + r < 9 || n + r > 12) begin errors++; $display("FAIL freeze_resume got %0d want 9..12", n + r); end
    run_length(1'b1, r);
    game_over = 1'b1;
    place_bomb();
    repeat (4) @(negedge clk);
    checks++; if (bomb_active !== 1'b0) begin errors++; $display("FAIL freeze_place got %b want 0", bomb_active); end
    game_over = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bomb_active !== 1'b0) begin errors++; $display("FAIL freeze_stale_edge got %b want 0", bomb_active); end
  endtask

  task automatic test_async_reset();
    bit ok;
    b_x = 10'd128; b_y = 10'd112;
    v_x = 10'(XO + 5 * TPX + 3); v_y = 10'(YO + 5 * TPX + 3);
    place_bomb();
    wait_exp(ok);
    checks++; if (exp_on !== 1'b1) begin errors++; $display("FAIL pre_reset_exp_on got %b want 1", exp_on); end
    #2 reset = 1'b1;
    #1;
    checks++; if (exp_active !== 1'b0 || bomb_active !== 1'b0) begin errors++; $display("FAIL areset_state got %b%b want 00", bomb_active, exp_active); end
    checks++; if (bomb_tx !== 6'd0 || bomb_ty !== 6'd0) begin errors++; $display("FAIL areset_tile got %0d,%0d want 0,0", bomb_tx, bomb_ty); end
    checks++; if (exp_on !== 1'b0 || player_hit !== 1'b0 || bomb_on !== 1'b0) begin errors++; $display("FAIL areset_flags got %b%b%b want 000", exp_on, player_hit, bomb_on); end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bomb_active !== 1'b0 || exp_active !== 1'b0) begin errors++; $display("FAIL areset_idle got %b%b want 00", bomb_active, exp_active); end
  endtask

  task automatic test_random();
    bit e_bomb_on, e_exp_on, e_hit, in_arena;
    int ptx, pty;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      in_arena = (int'(v_x) >= XO) && (int'(v_y) >= YO);
      ptx = in_arena ? (int'(v_x) - XO) / TPX : -1;
      pty = in_arena ? (int'(v_y) - YO) / TPX : -1;
      e_bomb_on = (m_phase == 1) && in_arena && ptx == m_tx && pty == m_ty;
      e_exp_on  = (m_phase == 2) && in_arena && in_blast(ptx, pty, m_tx, m_ty);
      e_hit     = (m_phase == 2) && !m_hit_done &&
                  in_blast(snap_c(int'(b_x), XO), snap_c(int'(b_y), YO), m_tx, m_ty);
      checks++; if (bomb_active !== (m_phase == 1)) begin errors++; $display("FAIL rnd_bomb_active cyc %0d got %b want %b", i, bomb_active, m_phase == 1); end
      checks++; if (exp_active !== (m_phase == 2)) begin errors++; $display("FAIL rnd_exp_active cyc %0d got %b want %b", i, exp_active, m_phase == 2); end
      checks++; if (bomb_tx !== 6'(m_tx) || bomb_ty !== 6'(m_ty)) begin errors++; $display("FAIL rnd_tile cyc %0d got %0d,%0d want %0d,%0d", i, bomb_tx, bomb_ty, m_tx, m_ty); end
      checks++; if (bomb_on !== e_bomb_on) begin errors++; $display("FAIL rnd_bomb_on cyc %0d got %b want %b", i, bomb_on, e_bomb_on); end
      checks++; if (exp_on !== e_exp_on) begin errors++; $display("FAIL rnd_exp_on cyc %0d got %b want %b", i, exp_on, e_exp_on); end
      checks++; if (player_hit !== e_hit) begin errors++; $display("FAIL rnd_player_hit cyc %0d got %b want %b", i, player_hit, e_hit); end
      C   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 19) == 0) game_over = ~game_over;
      if ($urandom_range(0, 3) == 0) begin
        b_x = 10'($urandom_range(0, 200));
        b_y = 10'($urandom_range(0, 200));
      end
      v_x = 10'($urandom_range(0, 250));
      v_y = 10'($urandom_range(0, 250));
    end
    game_over = 1'b0;
    C = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_placement();
    test_snap();
    test_hold();
    test_cross();
    test_freeze();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
